// File: rtl/prod_accumulator_if.sv
// Valid/ready bundle between the multiplier product stream, the accumulator
// and the consumer of group sums.
interface prod_accumulator_if #(
  parameter int PROD_W = 7,
  parameter int ACC_W  = 9
);
  logic [PROD_W-1:0] prod;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  sum;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output prod, in_valid, out_ready,
    input  in_ready, sum, ovf, out_valid
  );

  modport slave (
    input  prod, in_valid, out_ready,
    output in_ready, sum, ovf, out_valid
  );
endinterface

// File: rtl/prod_accumulator.sv
// Sums groups of N_TERMS unsigned products and presents each group sum, with a
// sticky wrap flag, on a valid/ready output that holds until accepted.
module prod_accumulator #(
  parameter int PROD_W  = 7,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  prod_accumulator_if.slave bus,
  output logic [3:0]        term_cnt
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam int         EXT_W     = ACC_W + 1;
  localparam logic [3:0] LAST_TERM = 4'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             grpOvf_q, grpOvf_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [EXT_W-1:0] addFull;

  assign accept  = bus.in_valid && (state_q == ACCUM);
  // The extra top bit is the carry out of the accumulator width.
  assign addFull = {1'b0, acc_q} + EXT_W'(bus.prod);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    grpOvf_d = grpOvf_q;
    ovf_d    = ovf_q;

    if (clear) begin
      state_d  = ACCUM;
      acc_d    = '0;
      sum_d    = '0;
      cnt_d    = '0;
      grpOvf_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == LAST_TERM) begin
              sum_d    = addFull[ACC_W-1:0];
              ovf_d    = grpOvf_q | addFull[ACC_W];
              acc_d    = '0;
              cnt_d    = '0;
              grpOvf_d = 1'b0;
              state_d  = DONE;
            end else begin
              acc_d    = addFull[ACC_W-1:0];
              grpOvf_d = grpOvf_q | addFull[ACC_W];
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      grpOvf_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      grpOvf_q <= grpOvf_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign term_cnt      = cnt_q;

endmodule
